// File: rtl/risc_boot_pkg.sv
// risc_boot_pkg: shared state encoding and default widths for the Risc boot loader.
package risc_boot_pkg;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
endpackage

// File: rtl/risc_word_packer.sv
// risc_word_packer: assembles little-endian bytes into words and keeps the running XOR.
module risc_word_packer
  import risc_boot_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        data,
  output logic [DATA_W-1:0] word,
  output logic              word_done,
  output logic [7:0]        xor_sum
);
  logic [1:0]        lane;
  logic [DATA_W-1:0] sr;
  // Bytes enter at the top and shift down, so the first byte ends up as the LSB.
  assign word = {data, sr[DATA_W-1:8]};
  assign word_done = take && lane == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      lane <= '0;
      sr <= '0;
      xor_sum <= '0;
    end else if (clear) begin
      lane <= '0;
      sr <= '0;
      xor_sum <= '0;
    end else if (take) begin
      lane <= lane + 2'd1;
      sr <= word;
      xor_sum <= xor_sum ^ data;
    end
endmodule

// File: rtl/risc_boot_loader.sv
// risc_boot_loader: loads a checksummed byte stream into the Risc core's instruction memory
// and releases io_boot once the image is verified.
module risc_boot_loader
  import risc_boot_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              io_boot,
  output logic              io_isWr,
  output logic [ADDR_W-1:0] io_wrAddr,
  output logic [DATA_W-1:0] io_wrData,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t            state, state_nx;
  logic [7:0]        left;
  logic [ADDR_W-1:0] idx;
  logic              xfer, word_done;
  logic [DATA_W-1:0] word;
  logic [7:0]        xor_sum;
  assign in_ready = state inside {COUNT, DATA, CHECK};
  assign busy = in_ready;
  assign io_boot = in_ready || state == ERR;
  assign done = state == DONE;
  assign error = state == ERR;
  assign xfer = in_valid && in_ready;
  risc_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clock(clock),
    .reset(reset),
    .clear(state == COUNT),
    .take(xfer && state == DATA),
    .data(in_data),
    .word(word),
    .word_done(word_done),
    .xor_sum(xor_sum)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: state_nx = start ? COUNT : state;
      COUNT:           state_nx = xfer ? (in_data == 8'd0 ? CHECK : DATA) : COUNT;
      DATA:            state_nx = word_done && left == 8'd1 ? CHECK : DATA;
      CHECK:           state_nx = xfer ? (in_data == xor_sum ? DONE : ERR) : CHECK;
      default:         state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // left counts words still owed; idx is the address of the next word to write.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      left <= '0;
      idx <= '0;
      io_isWr <= 1'b0;
      io_wrAddr <= '0;
      io_wrData <= '0;
    end else begin
      io_isWr <= word_done;
      if (state == COUNT) begin
        idx <= '0;
        if (xfer) left <= in_data;
      end else if (word_done) begin
        left <= left - 8'd1;
        idx <= idx + 1'b1;
        io_wrAddr <= idx;
        io_wrData <= word;
      end
    end
endmodule

// File: tb/tb_risc_boot_loader.sv
// tb_risc_boot_loader: randomized and directed loads checked every cycle against a stream-level model.
module tb_risc_boot_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, io_boot, io_isWr, busy, done, error;
  logic [7:0]  io_wrAddr;
  logic [31:0] io_wrData;
  int n_chk = 0;
  int n_fail = 0;

  risc_boot_loader #(.DATA_W(32), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .io_boot(io_boot), .io_isWr(io_isWr), .io_wrAddr(io_wrAddr),
    .io_wrData(io_wrData), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 done, 3 error; pos = bytes accepted in this load.
  int          phase = 0;
  int          pos = 0;
  int          n = 0;
  logic [7:0]  xacc = 8'd0;
  logic [31:0] wbuf = 32'd0;
  logic        m_wr = 1'b0;
  logic [7:0]  m_addr = 8'd0;
  logic [31:0] m_data = 32'd0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase = 0; pos = 0; m_wr = 1'b0; m_addr = 8'd0; m_data = 32'd0;
    end else begin
      m_wr = 1'b0;
      if (phase != 1) begin
        if (start) begin phase = 1; pos = 0; xacc = 8'd0; end
      end else if (in_valid) begin
        if (pos == 0) n = int'(in_data);
        else if (pos <= 4 * n) begin
          xacc ^= in_data;
          wbuf[8 * ((pos - 1) % 4) +: 8] = in_data;
          if ((pos - 1) % 4 == 3) begin
            m_wr = 1'b1; m_addr = 8'((pos - 1) / 4); m_data = wbuf;
          end
        end else phase = (in_data == xacc) ? 2 : 3;
        pos++;
      end
    end
  end

  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clock) begin
    chk("in_ready", in_ready, phase == 1);
    chk("io_boot", io_boot, phase == 1 || phase == 3);
    chk("busy", busy, phase == 1);
    chk("done", done, phase == 2);
    chk("error", error, phase == 3);
    chk("io_isWr", io_isWr, m_wr);
    chk("io_wrAddr", io_wrAddr, m_addr);
    chk("io_wrData", io_wrData, m_data);
    if (io_isWr) begin log_addr.push_back(io_wrAddr); log_data.push_back(io_wrData); end
  end

  task automatic do_start(input logic with_byte);
    @(negedge clock); #1;
    start = 1'b1; in_valid = with_byte; in_data = 8'($urandom);
    @(posedge clock);
  endtask

  task automatic send(input logic [7:0] b, input bit gaps, input bit extra_start);
    bit acc = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clock); #1;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = in_valid ? b : 8'($urandom);
      start = extra_start && $urandom_range(0, 4) == 0;
      acc = in_valid && in_ready;
      @(posedge clock);
    end
    if (!acc) begin n_chk++; n_fail++; $display("FAIL send_timeout: byte %0h never accepted", b); end
  endtask

  task automatic idle(input int c);
    repeat (c) begin @(negedge clock); #1; start = 1'b0; in_valid = 1'b0; end
  endtask

  task automatic load(input logic [7:0] q[$], input bit gaps, input bit extra_start);
    log_addr.delete(); log_data.delete();
    do_start(gaps);
    foreach (q[i]) send(q[i], gaps, extra_start);
    @(negedge clock); #1; start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] s[$];
    in_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_boot", io_boot, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    #1 reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_ready", in_ready, 1'b0);
    chk("idle_wr_count", log_addr.size(), 0);
    idle(1);

    s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h12};
    load(s, 0, 0);
    chk("two_word_count", log_addr.size(), 2);
    chk("two_word_a0", {log_addr[0], log_data[0]}, {8'd0, 32'h13});
    chk("two_word_a1", {log_addr[1], log_data[1]}, {8'd1, 32'h1});
    chk("two_word_done", {done, io_boot, error}, 3'b100);
    idle(2);

    s[9] = 8'h00;
    load(s, 0, 0);
    chk("bad_cs_count", log_addr.size(), 2);
    idle(5);
    chk("bad_cs_flags", {done, io_boot, error}, 3'b011);

    load('{8'h00, 8'h00}, 0, 0);
    chk("empty_flags", {done, io_boot, error}, 3'b100);
    chk("empty_wr_count", log_addr.size(), 0);
    idle(2);

    s[9] = 8'h12;
    load(s, 1, 1);
    chk("gapped_count", log_addr.size(), 2);
    chk("gapped_a1", {log_addr[1], log_data[1]}, {8'd1, 32'h1});
    chk("gapped_done", done, 1'b1);
    idle(2);

    do_start(0);
    s = '{8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    foreach (s[i]) send(s[i], 0, 0);
    @(negedge clock); #1 reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    #1;
    chk("abort_outputs", {in_ready, io_boot, io_isWr, io_wrAddr, io_wrData, busy, done, error}, '0);
    @(negedge clock); #1 reset = 1'b1;
    idle(2);
    s = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    load(s, 0, 0);
    chk("after_abort_wr", {log_addr[0], log_data[0]}, {8'd0, 32'hDEADBEEF});
    chk("after_abort_done", done, 1'b1);
    idle(2);

    for (int it = 0; it < 10; it++) begin
      int nw = $urandom_range(0, 6);
      logic [7:0] cs = 8'd0;
      logic [7:0] b;
      s.delete(); s.push_back(8'(nw));
      for (int k = 0; k < 4 * nw; k++) begin b = 8'($urandom); cs ^= b; s.push_back(b); end
      s.push_back($urandom_range(0, 2) == 0 ? cs ^ 8'($urandom_range(1, 255)) : cs);
      load(s, it[0], it[1]);
      chk("rand_wr_count", log_addr.size(), nw);
      idle($urandom_range(0, 3));
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/risc_boot_loader.md
# risc_boot_loader

Upstream program loader for the `Risc` core. It accepts a byte stream with a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into the core's instruction memory through the core's `io_boot`/`io_wrAddr`/`io_wrData`/`io_isWr` port, then releases `io_boot` so the core starts executing from address 0. A trailing XOR checksum guards the image, and a mismatch keeps the core held in boot.

## Interface

Parameters:
- `DATA_W`, 32: instruction word width; must equal the core's `io_wrData` width.
- `ADDR_W`, 8: instruction memory address width; must equal the core's `io_wrAddr` width.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-low reset; the block is in reset while the pin is 0.
- `start`  in  1  one-cycle request to begin a load.
- `in_valid`  in  1  the byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  the block accepts a byte this cycle.
- `io_boot`  out  1  holds the core in boot/load mode.
- `io_isWr`  out  1  one-cycle instruction memory write strobe.
- `io_wrAddr`  out  ADDR_W  write word address.
- `io_wrData`  out  DATA_W  write word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed with a good checksum.
- `error`  out  1  the last load failed its checksum.

## Operation

- Stream format: count byte N (0..255), then 4N data bytes with the least significant byte of each word first, then one checksum byte.
- The checksum is the XOR of the 4N data bytes only; the count byte is excluded.
- A byte is transferred only when `in_valid && in_ready` are both high.
- FSM states:
  - IDLE: `in_ready`=0. `start` moves to COUNT.
  - COUNT: `in_ready`=1. The accepted byte loads the word counter. N=0 moves to CHECK; otherwise moves to DATA.
  - DATA: `in_ready`=1. Bytes fill the packer. On the 4th byte of a word a write is issued and the word index increments. After word N-1, moves to CHECK.
  - CHECK: `in_ready`=1. On the accepted byte, a match moves to DONE and a mismatch moves to ERR.
  - DONE: `io_boot`=0, `done`=1. `start` moves to COUNT.
  - ERR: `io_boot`=1, `error`=1. `start` moves to COUNT.
- `io_boot`=1 in COUNT, DATA, CHECK and ERR, and 0 in IDLE and DONE.
- `busy`=1 in COUNT, DATA and CHECK.
- `done` and `error` are sticky and clear when a new load leaves DONE/ERR.
- Word i is written to `io_wrAddr`=i. Addresses run 0..N-1 with N≤255, so no wrap-around is possible.
- `start` is ignored in COUNT, DATA and CHECK.
- An asserted `reset` at any point aborts the load and discards any partial word. Memory already written is left as is.

## Timing

- Reset values: `in_ready`=0, `io_boot`=0, `io_isWr`=0, `io_wrAddr`=0, `io_wrData`=0, `busy`=0, `done`=0, `error`=0. The FSM resets to IDLE.
- `io_boot` and `busy` rise the cycle after `start` is sampled.
- `io_isWr` is registered: it is high for exactly one cycle, the cycle after the 4th byte handshake. `io_wrAddr` and `io_wrData` are stable in that cycle.
- `io_wrAddr` and `io_wrData` hold their last values when `io_isWr`=0.
- No back-pressure is caused by writes. `in_ready` stays 1 across word boundaries, so full throughput is 1 byte per cycle and one write every 4 cycles.
- A checksum byte accepted in cycle k gives `io_boot`=0 and `done`/`error` in cycle k+1.
- The last `io_isWr` always precedes the fall of `io_boot` by at least 1 cycle.
- In ERR, `io_boot` stays 1 indefinitely.
- If `start` arrives in the same cycle a byte is offered while in IDLE, the byte is not accepted.

## Structure

- Package `risc_boot_pkg` holds:
  - the state enum (IDLE, COUNT, DATA, CHECK, DONE, ERR);
  - `BYTES_PER_WORD`=4;
  - the default widths.
- Sub-module `risc_word_packer` contains:
  - the 2-bit byte lane counter and the 32-bit shift/assembly register;
  - the running XOR;
  - a `word_done` pulse.
- The top level holds the FSM, the word counter/address register and the registered write port.

## Test plan

- Reset and idle: hold `reset`=0, then release with no `start` -> all outputs 0 and no `io_isWr`, even with `in_valid` held at 1.
- Two-word load: `start`, then bytes 02, 13,00,00,00, 01,00,00,00, checksum 12 at 1 byte/cycle -> `io_isWr` at addr 0 with 0x00000013, then addr 1 with 0x00000001; `io_boot` falls and `done`=1 one cycle after the checksum byte.
- Bad checksum: same stream with checksum 0x00 -> both writes still occur; `error`=1, `io_boot` stays 1, `done`=0.
- Empty image: `start`, bytes 00, 00 -> no `io_isWr`; `done`=1 and `io_boot`=0 two cycles after the count byte.
- Gapped stream and ignored `start`: toggle `in_valid` randomly and pulse `start` mid-load -> same writes as the gap-free run, and the extra `start` has no effect.
- Reset mid-load: assert `reset` after 6 data bytes -> outputs go immediately to reset values; a following complete load writes from addr 0 correctly.
